// File: rtl/fwd_hazard_unit_pkg.sv
// Shared definitions for the forwarding/hazard unit and the EX-stage operand muxes:
// forward-select codes and the pipeline slot record.
package fwd_hazard_unit_pkg;

  // Slot dest fields are sized for the widest supported register address;
  // narrower addresses are zero-extended, which preserves equality and the $0 test.
  localparam int MAX_REG_ADDR_W = 8;

  typedef logic [1:0] fwd_sel_t;

  localparam fwd_sel_t FWD_REG   = 2'b00;
  localparam fwd_sel_t FWD_WB    = 2'b01;
  localparam fwd_sel_t FWD_EXMEM = 2'b10;

  typedef struct packed {
    logic                      valid;
    logic [MAX_REG_ADDR_W-1:0] dest;
    logic                      regwrite;
    logic                      memread;
  } slot_t;

  localparam slot_t SLOT_BUBBLE = '0;

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// ID-stage request / hazard-response bundle between the decode stage and fwd_hazard_unit.
// Optional macro HAZ_STALL_CNT_EN adds the stall_count signal.
interface fwd_hazard_unit_if
  import fwd_hazard_unit_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
);

  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_rs;
  logic [REG_ADDR_W-1:0] id_rt;
  logic [REG_ADDR_W-1:0] id_dest;
  logic                  id_regwrite;
  logic                  id_memread;
  logic                  flush;

  logic                  stall;
  fwd_sel_t              forwardOp1;
  fwd_sel_t              forwardOp2;
  slot_t                 ex_slot;
  slot_t                 mem_slot;
  slot_t                 wb_slot;
`ifdef HAZ_STALL_CNT_EN
  logic [CNT_W-1:0]      stall_count;

  modport master (
    output id_valid, id_rs, id_rt, id_dest, id_regwrite, id_memread, flush,
    input  stall, forwardOp1, forwardOp2, ex_slot, mem_slot, wb_slot, stall_count
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_dest, id_regwrite, id_memread, flush,
    output stall, forwardOp1, forwardOp2, ex_slot, mem_slot, wb_slot, stall_count
  );
`else
  modport master (
    output id_valid, id_rs, id_rt, id_dest, id_regwrite, id_memread, flush,
    input  stall, forwardOp1, forwardOp2, ex_slot, mem_slot, wb_slot
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_dest, id_regwrite, id_memread, flush,
    output stall, forwardOp1, forwardOp2, ex_slot, mem_slot, wb_slot
  );
`endif

endinterface

// File: rtl/fwd_hazard_unit_fwd_cmp.sv
// Forward-select for one source register: EX-slot producer beats MEM-slot producer,
// register 0 never forwards.
module fwd_cmp
  import fwd_hazard_unit_pkg::*;
(
  input  logic [MAX_REG_ADDR_W-1:0] src,
  input  slot_t                     ex,
  input  slot_t                     mem,
  output fwd_sel_t                  sel
);

  logic src_nz;
  logic ex_hit;
  logic mem_hit;
  logic unused_memread;

  assign src_nz  = (src != '0);
  assign ex_hit  = ex.valid  && ex.regwrite  && (ex.dest  == src) && src_nz;
  assign mem_hit = mem.valid && mem.regwrite && (mem.dest == src) && src_nz;

  // Load-ness only matters for the stall decision, not for the select code.
  assign unused_memread = ex.memread ^ mem.memread;

  assign sel = ex_hit ? FWD_EXMEM : (mem_hit ? FWD_WB : FWD_REG);

endmodule

// File: rtl/fwd_hazard_unit.sv
// Load-use stall detection and registered EX-stage operand forwarding for a 5-stage pipe.
// Optional macro HAZ_STALL_CNT_EN adds a saturating load-use stall counter.
module fwd_hazard_unit
  import fwd_hazard_unit_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
)(
  input logic              clk,
  input logic              rst,
  fwd_hazard_unit_if.slave bus
);

  slot_t    ex_q, mem_q, wb_q;
  fwd_sel_t fwd1_q, fwd2_q;
  fwd_sel_t sel_rs, sel_rt;

  logic [MAX_REG_ADDR_W-1:0] rs_w, rt_w, dest_w;
  logic                      load_use;
  logic                      stall_w;
  logic                      kill;

  assign rs_w   = MAX_REG_ADDR_W'(bus.id_rs);
  assign rt_w   = MAX_REG_ADDR_W'(bus.id_rt);
  assign dest_w = MAX_REG_ADDR_W'(bus.id_dest);

  assign load_use = bus.id_valid && ex_q.valid && ex_q.memread && (ex_q.dest != '0) &&
                    ((ex_q.dest == rs_w) || (ex_q.dest == rt_w));

  // NOTE: stall is a function of current state only, so an asserted rst clears it
  // one cycle later once the EX slot has been emptied, not in the same cycle.
  assign stall_w = load_use && !bus.flush;
  assign kill    = stall_w || bus.flush;

  fwd_cmp u_cmp_rs (.src(rs_w), .ex(ex_q), .mem(mem_q), .sel(sel_rs));
  fwd_cmp u_cmp_rt (.src(rt_w), .ex(ex_q), .mem(mem_q), .sel(sel_rt));

  // NOTE: whole slots are cleared on reset, not just valid, so dest/regwrite never
  // carry X into the comparators on the first cycles after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q   <= SLOT_BUBBLE;
      mem_q  <= SLOT_BUBBLE;
      wb_q   <= SLOT_BUBBLE;
      fwd1_q <= FWD_REG;
      fwd2_q <= FWD_REG;
    end else begin
      mem_q <= ex_q;
      wb_q  <= mem_q;
      if (kill) begin
        ex_q   <= SLOT_BUBBLE;
        fwd1_q <= FWD_REG;
        fwd2_q <= FWD_REG;
      end else begin
        ex_q   <= '{valid: bus.id_valid, dest: dest_w,
                    regwrite: bus.id_regwrite, memread: bus.id_memread};
        fwd1_q <= sel_rs;
        fwd2_q <= sel_rt;
      end
    end
  end

  assign bus.stall      = stall_w;
  assign bus.forwardOp1 = fwd1_q;
  assign bus.forwardOp2 = fwd2_q;
  assign bus.ex_slot    = ex_q;
  assign bus.mem_slot   = mem_q;
  assign bus.wb_slot    = wb_q;

`ifdef HAZ_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (stall_w && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign bus.stall_count = stall_cnt_q;
`endif

endmodule
